// File: rtl/fourstate_alu_pkg.sv
// Shared types for the 4-state operator pipe: opcodes, beat/result records, mask helpers.
// Words are carried at WORD_MAX bits; units narrower than that keep the upper bits at zero.
package fourstate_alu_pkg;

    localparam int unsigned WORD_MAX = 64;

    typedef logic [WORD_MAX-1:0] word_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_MOD  = 4'd4,
        OP_LE   = 4'd5,
        OP_EQ   = 4'd6,
        OP_CEQ  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_XNOR = 4'd11,
        OP_RAND = 4'd12,
        OP_RXOR = 4'd13,
        OP_SHL  = 4'd14,
        OP_SHR  = 4'd15
    } op_e;

    typedef struct packed {
        op_e   op;
        word_t a;
        word_t a_x;
        word_t b;
        word_t b_x;
    } beat_t;

    typedef struct packed {
        word_t res;
        word_t res_x;
        logic  err;
    } result_t;

    // Ones in the low w bits; w == WORD_MAX wraps to all ones.
    function automatic word_t width_mask(input int unsigned w);
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    // Operators whose result becomes fully unknown if any operand bit is unknown.
    function automatic logic x_floods(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_LE, OP_EQ};
    endfunction

    function automatic logic is_bit_result(input op_e op);
        return op inside {OP_LE, OP_EQ, OP_CEQ, OP_RAND, OP_RXOR};
    endfunction

endpackage

// File: rtl/fourstate_alu_core.sv
// Combinational 4-state evaluator: value+mask operands in, canonical value+mask result out.
// Latency: none (pure logic). Backpressure: not applicable.
// X-propagation is enabled by FOURSTATE_ALU_XPROP_EN; otherwise masks are ignored and res_x is 0.
module fourstate_alu_core
    import fourstate_alu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  beat_t   beat,
    output result_t result
);

`ifdef FOURSTATE_ALU_XPROP_EN
    localparam logic XPROP_EN = 1'b1;
`else
    localparam logic XPROP_EN = 1'b0;
`endif

    localparam word_t WMASK   = width_mask(W);
    localparam word_t WIDTH_W = word_t'(W);

    word_t av;
    word_t ax;
    word_t bv;
    word_t bx;
    word_t v;
    word_t x;
    logic  any_x;
    logic  b_zero;
    logic  err;

    always_comb begin
        // Value bits under a set mask bit are dropped, so Z and X behave the same.
        ax     = beat.a_x & WMASK & {WORD_MAX{XPROP_EN}};
        bx     = beat.b_x & WMASK & {WORD_MAX{XPROP_EN}};
        av     = beat.a & WMASK & ~ax;
        bv     = beat.b & WMASK & ~bx;
        any_x  = |{ax, bx};
        b_zero = (bx == '0) && (bv == '0);

        v   = '0;
        x   = '0;
        err = 1'b0;

        case (beat.op)
            OP_ADD: v = av + bv;
            OP_SUB: v = av - bv;
            OP_MUL: v = av * bv;
            OP_DIV, OP_MOD: begin
                if (b_zero) begin
                    err = 1'b1;
                    x   = WMASK;
                end else if (beat.op == OP_DIV) begin
                    v = av / bv;
                end else begin
                    v = av % bv;
                end
            end
            OP_LE:  v = word_t'(av <= bv);
            OP_EQ:  v = word_t'(av == bv);
            OP_CEQ: v = word_t'((av == bv) && (ax == bx));
            OP_AND: begin
                // A known 0 on either side dominates any unknown.
                x = (ax | bx) & ~((~av & ~ax) | (~bv & ~bx));
                v = av & bv;
            end
            OP_OR: begin
                x = (ax | bx) & ~(av | bv);
                v = av | bv;
            end
            OP_XOR: begin
                x = ax | bx;
                v = av ^ bv;
            end
            OP_XNOR: begin
                x = ax | bx;
                v = ~(av ^ bv);
            end
            OP_RAND: begin
                if (|(~av & ~ax & WMASK)) begin
                    v = '0;
                end else if (|ax) begin
                    x = word_t'(1);
                end else begin
                    v = word_t'(1);
                end
            end
            OP_RXOR: begin
                if (|ax) begin
                    x = word_t'(1);
                end else begin
                    v = word_t'(^av);
                end
            end
            OP_SHL: begin
                if (|bx) begin
                    x = WMASK;
                end else if (bv < WIDTH_W) begin
                    v = av << bv;
                    x = ax << bv;
                end
            end
            OP_SHR: begin
                if (|bx) begin
                    x = WMASK;
                end else if (bv < WIDTH_W) begin
                    v = av >> bv;
                    x = ax >> bv;
                end
            end
        endcase

        if (x_floods(beat.op) && any_x) begin
            x = is_bit_result(beat.op) ? word_t'(1) : WMASK;
        end

        // Canonical form: value reads 0 wherever the mask is set.
        x = x & WMASK;
        v = v & WMASK & ~x;

        result.res   = v;
        result.res_x = x & {WORD_MAX{XPROP_EN}};
        result.err   = err;
    end

endmodule

// File: rtl/fourstate_alu_pipe.sv
// Two-stage 4-state operator pipe (S1 operand register, S2 result register); FOURSTATE_ALU_XPROP_EN enables X-propagation.
// Latency: a beat accepted on cycle N presents out_valid on cycle N+2; one beat per cycle sustained.
// Backpressure: out_ready low freezes S2 outputs; in_ready = !s1_v || !s2_v || out_ready.
module fourstate_alu_pipe
    import fourstate_alu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] a_x,
    input  logic [W-1:0] b,
    input  logic [W-1:0] b_x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res,
    output logic [W-1:0] res_x,
    output logic         err
);

    localparam word_t WMASK = width_mask(W);

    beat_t   s1_q;
    result_t s2_q;
    result_t core_res;
    logic    s1_v;
    logic    s2_v;
    logic    s2_adv;

    assign s2_adv   = !s2_v || out_ready;
    assign in_ready = !s1_v || s2_adv;

    fourstate_alu_core #(
        .W (W)
    ) u_core (
        .beat   (s1_q),
        .result (core_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (in_ready) begin
                s1_v <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_q <= '{op: op_e'(op), a: word_t'(a), a_x: word_t'(a_x),
                          b: word_t'(b), b_x: word_t'(b_x)};
            end
            if (s2_adv) begin
                s2_v <= s1_v;
            end
            if (s2_adv && s1_v) begin
                s2_q <= core_res;
            end
        end
    end

    assign out_valid = s2_v;
    assign res       = s2_q.res[W-1:0];
    assign res_x     = s2_q.res_x[W-1:0];
    assign err       = s2_q.err;

    // Bits above W are always zero out of the core; fold them so they are not dangling.
    logic unused_hi;
    assign unused_hi = |((s2_q.res | s2_q.res_x) & ~WMASK);

endmodule

// File: tb/tb_fourstate_alu_pipe.sv
// Scoreboard bench for fourstate_alu_pipe at W=8: directed cases, backpressure, random traffic, mid-flight reset.
module tb_fourstate_alu_pipe;

    localparam int W = 8;
`ifdef FOURSTATE_ALU_XPROP_EN
    localparam bit XP = 1'b1;
`else
    localparam bit XP = 1'b0;
`endif

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3, MOD = 4'd4,
                           LE = 4'd5, EQ = 4'd6, CEQ = 4'd7, AND_ = 4'd8, OR_ = 4'd9,
                           XOR_ = 4'd10, XNOR_ = 4'd11, RAND = 4'd12, RXOR = 4'd13,
                           SHL = 4'd14, SHR = 4'd15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a, a_x, b, b_x;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res, res_x;
    logic         err;

    always #5 clk = ~clk;

    fourstate_alu_pipe #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .a_x(a_x), .b(b), .b_x(b_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .res_x(res_x), .err(err)
    );

    typedef struct {
        logic [7:0] r;
        logic [7:0] rx;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   ready_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each bit is 0, 1 or 2 (unknown); arithmetic uses plain integers.
    function automatic exp_t model(input logic [3:0] o, input logic [7:0] ai, axi, bi, bxi);
        exp_t r;
        int   ta[8];
        int   tb[8];
        int   av, bv, t, src, ones;
        bit   anyx, any0;
        r.r = 8'h00; r.rx = 8'h00; r.e = 1'b0;
        if (!XP) begin axi = 8'h00; bxi = 8'h00; end
        for (int i = 0; i < 8; i++) begin
            ta[i] = axi[i] ? 2 : int'(ai[i]);
            tb[i] = bxi[i] ? 2 : int'(bi[i]);
        end
        av   = int'(ai & ~axi);
        bv   = int'(bi & ~bxi);
        anyx = (axi != 0) || (bxi != 0);
        case (o)
            ADD: if (anyx) r.rx = 8'hFF; else r.r = 8'((av + bv) % 256);
            SUB: if (anyx) r.rx = 8'hFF; else r.r = 8'((av - bv + 256) % 256);
            MUL: if (anyx) r.rx = 8'hFF; else r.r = 8'((av * bv) % 256);
            DIV, MOD: begin
                if (bxi == 0 && bv == 0) begin
                    r.e = 1'b1;
                    r.rx = XP ? 8'hFF : 8'h00;
                end else if (anyx) r.rx = 8'hFF;
                else r.r = 8'((o == DIV) ? av / bv : av % bv);
            end
            LE:  if (anyx) r.rx = 8'h01; else r.r = {7'd0, av <= bv};
            EQ:  if (anyx) r.rx = 8'h01; else r.r = {7'd0, av == bv};
            CEQ: r.r = {7'd0, (av == bv) && (axi == bxi)};
            AND_, OR_, XOR_, XNOR_: begin
                for (int i = 0; i < 8; i++) begin
                    if (o == AND_)     t = (ta[i] == 0 || tb[i] == 0) ? 0 : (ta[i] == 2 || tb[i] == 2) ? 2 : 1;
                    else if (o == OR_) t = (ta[i] == 1 || tb[i] == 1) ? 1 : (ta[i] == 2 || tb[i] == 2) ? 2 : 0;
                    else if (ta[i] == 2 || tb[i] == 2) t = 2;
                    else t = (o == XOR_) ? (ta[i] != tb[i]) : (ta[i] == tb[i]);
                    if (t == 2) r.rx[i] = 1'b1; else r.r[i] = t[0];
                end
            end
            RAND: begin
                any0 = 1'b0;
                for (int i = 0; i < 8; i++) if (ta[i] == 0) any0 = 1'b1;
                if (any0) r.r = 8'h00; else if (axi != 0) r.rx = 8'h01; else r.r = 8'h01;
            end
            RXOR: begin
                ones = 0;
                for (int i = 0; i < 8; i++) if (ta[i] == 1) ones++;
                if (axi != 0) r.rx = 8'h01; else r.r = {7'd0, ones % 2 == 1};
            end
            default: begin
                if (bxi != 0) r.rx = 8'hFF;
                else if (bv < 8) begin
                    for (int i = 0; i < 8; i++) begin
                        src = (o == SHL) ? i - bv : i + bv;
                        if (src >= 0 && src < 8) begin
                            if (ta[src] == 2) r.rx[i] = 1'b1; else r.r[i] = ta[src][0];
                        end
                    end
                end
            end
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] ai, axi, bi, bxi, input exp_t e);
        int n = 0;
        op = o; a = ai; a_x = axi; b = bi; b_x = bxi;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        else sb.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    task automatic issue_c(input logic [3:0] o, input logic [7:0] ai, axi, bi, bxi,
                           input logic [7:0] er, erx, input logic ee);
        exp_t e;
        e.r = er; e.rx = erx; e.e = ee;
        issue(o, ai, axi, bi, bxi, e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        chk("drain_timeout", sb.size(), 32'd0);
    endtask

    always @(posedge clk) begin
        if (ready_rand) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expectations on output transfers and checks stall stability.
    initial begin
        exp_t       e;
        bit         held = 1'b0;
        logic [7:0] h_r, h_rx;
        logic       h_e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                continue;
            end
            if (held && out_valid) begin
                chk("stall_res", res, h_r);
                chk("stall_res_x", res_x, h_rx);
                chk("stall_err", err, h_e);
            end
            held = out_valid && !out_ready;
            h_r = res; h_rx = res_x; h_e = err;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("res", res, e.r);
                    chk("res_x", res_x, e.rx);
                    chk("err", err, e.e);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   stuck;
        exp_t e;
        logic [3:0] ro;
        logic [7:0] ra, rax, rb, rbx;

        rst_n = 1'b0; in_valid = 1'b0; op = 4'd0;
        a = '0; a_x = '0; b = '0; b_x = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_res", res, 32'd0);
        chk("rst_res_x", res_x, 32'd0);
        chk("rst_err", err, 32'd0);
        step();

        // Latency: ADD accepted at the first edge, visible two cycles later.
        op = ADD; a = 8'd5; b = 8'd10; a_x = '0; b_x = '0; in_valid = 1'b1;
        e.r = 8'd15; e.rx = 8'h00; e.e = 1'b0;
        @(negedge clk);
        chk("lat_in_ready", in_ready, 32'd1);
        sb.push_back(e);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1_valid", out_valid, 32'd0);
        @(negedge clk);
        chk("lat_n2_valid", out_valid, 32'd1);
        chk("lat_n2_res", res, 32'd15);
        chk("lat_n2_res_x", res_x, 32'd0);
        step();

        issue_c(SUB, 8'd5, 8'h00, 8'd10, 8'h00, 8'hFB, 8'h00, 1'b0);
        issue_c(DIV, 8'd10, 8'h00, 8'd0, 8'h00, 8'h00, XP ? 8'hFF : 8'h00, 1'b1);
        issue_c(MOD, 8'd10, 8'h00, 8'd3, 8'h00, 8'h01, 8'h00, 1'b0);
        issue_c(AND_, 8'h09, 8'h00, 8'h01, 8'h08, 8'h01, XP ? 8'h08 : 8'h00, 1'b0);
        issue_c(CEQ, 8'h01, 8'h08, 8'h01, 8'h08, 8'h01, 8'h00, 1'b0);
        issue_c(EQ, 8'h01, 8'h08, 8'h01, 8'h08, XP ? 8'h00 : 8'h01, XP ? 8'h01 : 8'h00, 1'b0);
        // Bits 7:4 of 8'h07 are known zeros, which dominate the unknown bit 3.
        issue_c(RAND, 8'h07, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        issue_c(RAND, 8'hF7, 8'h08, 8'h00, 8'h00, 8'h00, XP ? 8'h01 : 8'h00, 1'b0);
        issue_c(SHL, 8'h81, 8'h00, 8'd1, 8'h00, 8'h02, 8'h00, 1'b0);
        issue_c(SHR, 8'hFF, 8'h00, 8'd8, 8'h00, 8'h00, 8'h00, 1'b0);
        issue_c(SHL, 8'h01, 8'h00, 8'd1, 8'h01, XP ? 8'h00 : 8'h02, XP ? 8'hFF : 8'h00, 1'b0);
        issue_c(OR_, 8'h10, 8'h00, 8'h00, 8'h11, XP ? 8'h10 : 8'h10, XP ? 8'h01 : 8'h00, 1'b0);
        issue_c(XNOR_, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'hFF, 8'h00, 1'b0);
        issue_c(MUL, 8'd20, 8'h00, 8'd13, 8'h00, 8'h04, 8'h00, 1'b0);
        drain();

        // Backpressure: two beats fill the pipe, the third is held off.
        out_ready = 1'b0;
        issue_c(ADD, 8'd1, 8'h00, 8'd1, 8'h00, 8'd2, 8'h00, 1'b0);
        issue_c(ADD, 8'd2, 8'h00, 8'd2, 8'h00, 8'd4, 8'h00, 1'b0);
        op = ADD; a = 8'd3; b = 8'd3; a_x = '0; b_x = '0; in_valid = 1'b1;
        stuck = 0;
        repeat (4) begin
            @(negedge clk);
            if (in_ready) stuck++;
        end
        chk("bp_in_ready_low", stuck, 32'd0);
        chk("bp_out_valid", out_valid, 32'd1);
        step();
        out_ready = 1'b1;
        issue_c(ADD, 8'd3, 8'h00, 8'd3, 8'h00, 8'd6, 8'h00, 1'b0);
        issue_c(ADD, 8'd4, 8'h00, 8'd4, 8'h00, 8'd8, 8'h00, 1'b0);
        drain();

        // Random traffic with random consumer stalls.
        ready_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            ro  = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rax = ($urandom_range(0, 2) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
            rbx = ($urandom_range(0, 2) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
            if (ro == SHL || ro == SHR) rb = 8'($urandom_range(0, 10));
            if ((ro == DIV || ro == MOD) && $urandom_range(0, 3) == 0) rb = 8'h00;
            issue(ro, ra, rax, rb, rbx, model(ro, ra, rax, rb, rbx));
        end
        ready_rand = 1'b0;
        step();
        out_ready = 1'b1;
        drain();

        // Reset with two beats in flight: they must never emerge.
        out_ready = 1'b0;
        issue_c(ADD, 8'd7, 8'h00, 8'd7, 8'h00, 8'd14, 8'h00, 1'b0);
        issue_c(ADD, 8'd8, 8'h00, 8'd8, 8'h00, 8'd16, 8'h00, 1'b0);
        @(negedge clk);
        chk("mid_full_valid", out_valid, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 32'd0);
        chk("mid_rst_in_ready", in_ready, 32'd1);
        sb.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        stuck = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stuck++;
        end
        chk("post_rst_no_stale", stuck, 32'd0);
        step();
        issue_c(ADD, 8'd1, 8'h00, 8'd2, 8'h00, 8'd3, 8'h00, 1'b0);
        drain();
        repeat (3) step();
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
